// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the pixel pipeline (VESA 800x600@60 Hz, 40 MHz pixel clock).
// Draw stages import this to pick up the visible-area limits instead of hard-coding them.
package vga_timing_pkg;

  localparam int CNT_W = 11;

  localparam int VGA_H_VISIBLE = 800;
  localparam int VGA_H_FP      = 40;
  localparam int VGA_H_SYNC    = 128;
  localparam int VGA_H_BP      = 88;
  localparam int VGA_V_VISIBLE = 600;
  localparam int VGA_V_FP      = 1;
  localparam int VGA_V_SYNC    = 4;
  localparam int VGA_V_BP      = 23;
  localparam bit VGA_SYNC_POL  = 1'b1;

  localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // True when cnt lies in the half-open window [lo, lo+len).
  function automatic logic in_window(input logic [CNT_W-1:0] cnt, input int lo, input int len);
    return (int'(cnt) >= lo) && (int'(cnt) < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running horizontal/vertical counters with sync/blank decode. Every output is
// registered from the same next-count values, so all of them describe the same pixel.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter bit SYNC_POL  = VGA_SYNC_POL
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             hblnk,
  output logic             vsync,
  output logic             vblnk,
  output logic             frame_start,
  output logic             line_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_range_chk
    $error("vga_timing: line or frame total exceeds counter range");
  end

  logic [CNT_W-1:0] hcount_nxt;
  logic [CNT_W-1:0] vcount_nxt;
  logic             hsync_nxt;
  logic             hblnk_nxt;
  logic             vsync_nxt;
  logic             vblnk_nxt;
  logic             line_start_nxt;
  logic             frame_start_nxt;

  always_comb begin
    hcount_nxt = hcount + 1'b1;
    vcount_nxt = vcount;
    if (hcount == H_LAST) begin
      hcount_nxt = '0;
      vcount_nxt = (vcount == V_LAST) ? '0 : vcount + 1'b1;
    end
  end

  // Decode from the next counts so the registered flags line up with the registered counts.
  always_comb begin
    hblnk_nxt       = int'(hcount_nxt) >= H_VISIBLE;
    vblnk_nxt       = int'(vcount_nxt) >= V_VISIBLE;
    hsync_nxt       = in_window(hcount_nxt, H_VISIBLE + H_FP, H_SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync_nxt       = in_window(vcount_nxt, V_VISIBLE + V_FP, V_SYNC) ? SYNC_POL : ~SYNC_POL;
    line_start_nxt  = (hcount_nxt == '0);
    frame_start_nxt = line_start_nxt && (vcount_nxt == '0);
  end

  // Reset parks the raster on pixel (0,0) with its flags decoded, so release continues at (1,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
    end else begin
      hcount      <= hcount_nxt;
      vcount      <= vcount_nxt;
      hblnk       <= hblnk_nxt;
      vblnk       <= vblnk_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      line_start  <= line_start_nxt;
      frame_start <= frame_start_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default 1056-clock line, vertical timing shortened to 16 lines
// (8 visible, fp 1, sync 4, bp 3) so whole frames fit in a short run.
module tb_vga_timing;

  localparam int FRAME = 1056 * 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync, hblnk, vsync, vblnk, frame_start, line_start;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vga_timing #(
    .V_VISIBLE(8),
    .V_FP(1),
    .V_SYNC(4),
    .V_BP(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hcount(hcount),
    .vcount(vcount),
    .hsync(hsync),
    .hblnk(hblnk),
    .vsync(vsync),
    .vblnk(vblnk),
    .frame_start(frame_start),
    .line_start(line_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Hand-set window edges: hblnk 800.., hsync 840..967, vblnk 8.., vsync 9..12.
  function automatic logic [27:0] expect_vec(input int h, input int v);
    logic hs, hb, vs, vb, ls, fs;
    hs = (h >= 840) && (h < 968);
    hb = (h >= 800);
    vs = (v >= 9) && (v < 13);
    vb = (v >= 8);
    ls = (h == 0);
    fs = (h == 0) && (v == 0);
    return {11'(h), 11'(v), hs, hb, vs, vb, fs, ls};
  endfunction

  function automatic logic [27:0] observed();
    return {hcount, vcount, hsync, hblnk, vsync, vblnk, frame_start, line_start};
  endfunction

  // Starts at the first sample after reset release (pixel 1,0); ends sampling pixel (0,0).
  task automatic run_frame(input string tag);
    int h = 1;
    int v = 0;
    int fs_at = -1;
    int hs_pulses = 0;
    int vs_pulses = 0;
    int hs_len = 0;
    int v_bad = 0;
    logic hs_prev = 1'b0;
    logic vs_prev = 1'b0;
    logic vb_prev = 1'b0;
    for (int cyc = 1; cyc <= FRAME; cyc++) begin
      check({tag, "_pixel"}, {4'b0, observed()}, {4'b0, expect_vec(h, v)});
      if (hsync && !hs_prev) hs_pulses++;
      if (vsync && !vs_prev) vs_pulses++;
      if (v == 0 && hsync) hs_len++;
      if ((vsync !== vs_prev || vblnk !== vb_prev) && hcount != 11'd0) v_bad++;
      if (frame_start && fs_at < 0) fs_at = cyc;
      if (v == 0 && h == 799) check({tag, "_hblnk_799"}, 32'(hblnk), 32'd0);
      if (v == 0 && h == 800) check({tag, "_hblnk_800"}, 32'(hblnk), 32'd1);
      if (v == 6 && h == 0) begin
        check({tag, "_wrap_hcount"}, 32'(hcount), 32'd0);
        check({tag, "_wrap_vcount"}, 32'(vcount), 32'd6);
        check({tag, "_wrap_line_start"}, 32'(line_start), 32'd1);
        check({tag, "_wrap_frame_start"}, 32'(frame_start), 32'd0);
      end
      hs_prev = hsync;
      vs_prev = vsync;
      vb_prev = vblnk;
      h++;
      if (h == 1056) begin
        h = 0;
        v = (v == 15) ? 0 : v + 1;
      end
      if (cyc < FRAME) @(negedge clk);
    end
    check({tag, "_frame_period"}, 32'(fs_at), 32'(FRAME));
    check({tag, "_hsync_pulses"}, 32'(hs_pulses), 32'd16);
    check({tag, "_vsync_pulses"}, 32'(vs_pulses), 32'd1);
    check({tag, "_hsync_width"}, 32'(hs_len), 32'd128);
    check({tag, "_vflag_off_h0"}, 32'(v_bad), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_hcount", 32'(hcount), 32'd0);
    check("rst_vcount", 32'(vcount), 32'd0);
    check("rst_hblnk", 32'(hblnk), 32'd0);
    check("rst_vblnk", 32'(vblnk), 32'd0);
    check("rst_hsync", 32'(hsync), 32'd0);
    check("rst_vsync", 32'(vsync), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd1);
    check("rst_line_start", 32'(line_start), 32'd1);

    rst = 1'b0;
    @(negedge clk);
    check("rel_hcount", 32'(hcount), 32'd1);
    check("rel_vcount", 32'(vcount), 32'd0);
    check("rel_frame_start", 32'(frame_start), 32'd0);
    run_frame("f1");

    n = 0;
    while (!(hcount == 11'd900 && vcount == 11'd10) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached", 32'(n < 20000), 32'd1);
    check("mid_hsync", 32'(hsync), 32'd1);
    check("mid_vsync", 32'(vsync), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_outputs", {4'b0, observed()}, {4'b0, expect_vec(0, 0)});
    rst = 1'b0;
    @(negedge clk);
    check("mid_rel_hcount", 32'(hcount), 32'd1);
    run_frame("f2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
